// File: rtl/mem_stream_loader_pkg.sv
// Shared definitions for the stream loader: FSM states, write-mask constants
// and small helpers for tail masks and masked byte sums.
package mem_stream_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_VREQ  = 3'd3,
    S_VWAIT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] WMASK_FULL = 4'hF;

  // Mask for a word holding n valid low lanes; n == 0 means a full word.
  function automatic logic [3:0] tail_mask(input logic [1:0] n);
    logic [3:0] m;
    m = (n == 2'd0) ? WMASK_FULL : ((4'b0001 << n) - 4'b0001);
    return m;
  endfunction

  // Sum of the bytes of w whose lane is enabled in m.
  function automatic logic [31:0] masked_byte_sum(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) s = s + {24'd0, w[8*i +: 8]};
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_stream_loader_packer.sv
// Packs bytes little-endian into a 32-bit word. Presents the word and lane
// mask including the byte being pushed, and flushes on the 4th lane or on
// the last byte of the transfer so the next word starts clean at lane 0.
module mem_stream_loader_packer
  import mem_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic [3:0]  o_mask,
  output logic        o_flush
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [3:0]  r_mask;
  logic [31:0] w_word;
  logic [3:0]  w_mask;

  // Merge the incoming byte into its lane of the partially built word.
  always_comb begin
    w_word = r_word;
    case (r_lane)
      2'd0:    w_word[7:0]   = i_byte;
      2'd1:    w_word[15:8]  = i_byte;
      2'd2:    w_word[23:16] = i_byte;
      default: w_word[31:24] = i_byte;
    endcase
    w_mask = r_mask | (4'b0001 << r_lane);
  end

  assign o_word  = w_word;
  assign o_mask  = w_mask;
  assign o_flush = i_push && ((r_lane == 2'd3) || i_last);

  // Lane counter and pack register; cleared on a new load or after a flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lane <= 2'd0;
      r_word <= '0;
      r_mask <= '0;
    end else if (i_clear || o_flush) begin
      r_lane <= 2'd0;
      r_word <= '0;
      r_mask <= '0;
    end else if (i_push) begin
      r_lane <= r_lane + 2'd1;
      r_word <= w_word;
      r_mask <= w_mask;
    end
  end

endmodule

// File: rtl/mem_stream_loader.sv
// Loads a byte stream into word-addressed RAM, then reads the region back
// and compares a byte sum against the checksum of the received stream.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   RECV   | accepting stream bytes into the packer
//   WRITE  | one-cycle memory write of a packed word
//   VREQ   | read strobe for one verify word
//   VWAIT  | capture read data and accumulate verify sum
//   DONE   | load finished; done/error valid, start re-arms
module mem_stream_loader
  import mem_stream_loader_pkg::*;
#(
  parameter int MAX_LEN = 8192,
  parameter int LEN_W   = 16
)(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      base_addr,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  output logic             mem_rstrb,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  state_t           r_state;
  logic             r_s_ready, r_mem_rstrb, r_busy, r_done, r_error;
  logic [31:0]      r_mem_addr, r_mem_wdata, r_checksum, r_vsum;
  logic [3:0]       r_mem_wmask, r_last_mask;
  logic [31:0]      r_base, r_word_addr;
  logic [LEN_W-1:0] r_bytes_left, r_words_left, r_words_total;

  logic [LEN_W-1:0] w_len_eff, w_words;
  logic             w_start, w_push, w_flush, w_unused_base;
  logic [31:0]      w_pack_word, w_vsum_next;
  logic [3:0]       w_pack_mask, w_rd_mask;

  assign w_len_eff     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign w_words       = (w_len_eff + LEN_W'(3)) >> 2;
  assign w_start       = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_push        = (r_state == S_RECV) && s_valid;
  assign w_rd_mask     = (r_words_left == LEN_W'(1)) ? r_last_mask : WMASK_FULL;
  assign w_vsum_next   = r_vsum + masked_byte_sum(mem_rdata, w_rd_mask);
  assign w_unused_base = ^base_addr[1:0];

  mem_stream_loader_packer u_packer (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_start),
    .i_push  (w_push),
    .i_byte  (s_data),
    .i_last  (r_bytes_left == LEN_W'(1)),
    .o_word  (w_pack_word),
    .o_mask  (w_pack_mask),
    .o_flush (w_flush)
  );

  // Sequencer: byte intake, word writes, readback verify; outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_s_ready     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wmask   <= '0;
      r_mem_rstrb   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_checksum    <= '0;
      r_vsum        <= '0;
      r_base        <= '0;
      r_word_addr   <= '0;
      r_bytes_left  <= '0;
      r_words_left  <= '0;
      r_words_total <= '0;
      r_last_mask   <= WMASK_FULL;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_base        <= {base_addr[31:2], 2'b00};
            r_word_addr   <= {base_addr[31:2], 2'b00};
            r_bytes_left  <= w_len_eff;
            r_words_total <= w_words;
            r_last_mask   <= tail_mask(w_len_eff[1:0]);
            r_checksum    <= '0;
            r_vsum        <= '0;
            r_error       <= 1'b0;
            if (w_len_eff == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_RECV;
              r_done    <= 1'b0;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (s_valid) begin
            r_checksum   <= r_checksum + {24'd0, s_data};
            r_bytes_left <= r_bytes_left - LEN_W'(1);
            if (w_flush) begin
              r_state     <= S_WRITE;
              r_s_ready   <= 1'b0;
              r_mem_addr  <= r_word_addr;
              r_mem_wdata <= w_pack_word;
              r_mem_wmask <= w_pack_mask;
            end
          end
        end
        S_WRITE: begin
          r_mem_wmask <= '0;
          if (r_bytes_left != '0) begin
            r_state     <= S_RECV;
            r_s_ready   <= 1'b1;
            r_word_addr <= r_word_addr + 32'd4;
          end else begin
            r_state      <= S_VREQ;
            r_mem_rstrb  <= 1'b1;
            r_mem_addr   <= r_base;
            r_word_addr  <= r_base;
            r_words_left <= r_words_total;
          end
        end
        S_VREQ: begin
          r_mem_rstrb <= 1'b0;
          r_state     <= S_VWAIT;
        end
        S_VWAIT: begin
          r_vsum       <= w_vsum_next;
          r_words_left <= r_words_left - LEN_W'(1);
          if (r_words_left != LEN_W'(1)) begin
            r_state     <= S_VREQ;
            r_mem_rstrb <= 1'b1;
            r_mem_addr  <= r_word_addr + 32'd4;
            r_word_addr <= r_word_addr + 32'd4;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= (w_vsum_next != r_checksum);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign mem_rstrb = r_mem_rstrb;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Bench for mem_stream_loader: byte-addressed memory model with optional
// readback corruption, bus monitor, and a reference model that derives the
// expected word writes, verify reads and checksum from the byte list.
module tb_mem_stream_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] base_addr = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] mem_addr, mem_wdata, checksum;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, busy, done, error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          viol = 0;
  logic [31:0] mem_w [logic [31:0]];
  logic [7:0]  tx_bytes[$];
  logic        flip_en = 1'b0;
  logic [31:0] flip_addr = '0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;

  mem_stream_loader #(.MAX_LEN(8192), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .len(len), .base_addr(base_addr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_w.exists(a) ? mem_w[a] : 32'h0;
  endfunction

  // Memory model and bus monitor; read data is only meaningful in the cycle after a strobe.
  always @(negedge clk) begin : mem_model
    logic [31:0] word;
    if (mem_wmask != 4'h0) begin
      wr_q.push_back({mem_addr, mem_wdata, mem_wmask});
      word = mem_read(mem_addr);
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
      mem_w[mem_addr] = word;
    end
    if (mem_rstrb) rd_q.push_back(mem_addr);
    if (mem_wmask != 4'h0 && mem_rstrb) viol++;
    if (rd_pend)
      mem_rdata = mem_read(rd_addr) ^ ((flip_en && rd_addr == flip_addr) ? 32'h1 : 32'h0);
    else
      mem_rdata = $urandom();
    rd_pend = mem_rstrb;
    rd_addr = mem_addr;
  end

  // Reference model: expected writes straight from the byte list.
  function automatic int wr_errors(input logic [31:0] base, input int n);
    int errs = 0;
    int nw = (n + 3) / 4;
    logic [31:0] b0 = base & 32'hFFFF_FFFC;
    if (wr_q.size() != nw) errs++;
    for (int w = 0; w < nw && w < wr_q.size(); w++) begin
      logic [31:0] d = '0;
      logic [3:0]  m = '0;
      for (int b = 0; b < 4; b++)
        if (4*w + b < n) begin
          d[8*b +: 8] = tx_bytes[4*w + b];
          m[b] = 1'b1;
        end
      if (wr_q[w].addr !== b0 + 32'(4*w) || wr_q[w].data !== d || wr_q[w].mask !== m) errs++;
    end
    return errs;
  endfunction

  function automatic int rd_errors(input logic [31:0] base, input int n);
    int errs = 0;
    int nw = (n + 3) / 4;
    logic [31:0] b0 = base & 32'hFFFF_FFFC;
    if (rd_q.size() != nw) errs++;
    for (int w = 0; w < nw && w < rd_q.size(); w++)
      if (rd_q[w] !== b0 + 32'(4*w)) errs++;
    return errs;
  endfunction

  function automatic int img_errors(input logic [31:0] base, input int n);
    int errs = 0;
    logic [31:0] b0 = base & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      logic [31:0] word = mem_read(b0 + 32'(4*(i/4)));
      if (word[8*(i%4) +: 8] !== tx_bytes[i]) errs++;
    end
    return errs;
  endfunction

  function automatic logic [31:0] sum_bytes(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s = s + 32'(tx_bytes[i]);
    return s;
  endfunction

  // Drive one load; cyc counts negedges from the first post-start cycle until done.
  task automatic run_load(input logic [31:0] base, input logic [15:0] len_in, input int n_send,
                          input int gap_pct, input int glitch_cyc,
                          output int cyc, output logic b_after, output logic d_after);
    int idx = 0;
    int budget = 100 + 10 * n_send;
    logic [31:0] b0 = base & 32'hFFFF_FFFC;
    for (int w = 0; w <= n_send / 4; w++) mem_w[b0 + 32'(4*w)] = $urandom();
    wr_q.delete();
    rd_q.delete();
    cyc = 0;
    @(negedge clk);
    start = 1'b1; len = len_in; base_addr = base;
    @(negedge clk);
    start = 1'b0;
    b_after = busy;
    d_after = done;
    while (done !== 1'b1 && cyc < budget) begin
      start = (cyc == glitch_cyc);
      if (start) begin len = 16'd1; base_addr = 32'h0; end
      if (idx < n_send) begin
        s_valid = ($urandom_range(99) >= gap_pct);
        s_data  = tx_bytes[idx];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom());
      end
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    n_checks++;
    if ({s_ready, mem_wmask, mem_rstrb, busy, done, error} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b required 0", {s_ready, mem_wmask, mem_rstrb, busy, done, error});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, checksum} !== 96'd0) begin
      n_errors++;
      $display("FAIL reset_data: addr=%h wdata=%h sum=%h required all 0", mem_addr, mem_wdata, checksum);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_ready, busy, done, mem_wmask, mem_rstrb} !== 8'd0) begin
      n_errors++;
      $display("FAIL idle_quiet: got %b required 0", {s_ready, busy, done, mem_wmask, mem_rstrb});
    end
  endtask

  task automatic test_basic();
    int cyc; logic b, d;
    tx_bytes.delete();
    for (int i = 1; i <= 8; i++) tx_bytes.push_back(8'(i));
    run_load(32'h100, 16'd8, 8, 0, -1, cyc, b, d);
    n_checks++;
    if (b !== 1'b1 || d !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_busy_after_start: busy=%b done=%b required 1 0", b, d);
    end
    n_checks++;
    if (wr_q.size() !== 2) begin
      n_errors++;
      $display("FAIL basic_wr_count: got %0d required 2", wr_q.size());
    end
    n_checks++;
    if ((wr_q.size() > 0 ? wr_q[0] : '0) !== {32'h100, 32'h04030201, 4'hF}) begin
      n_errors++;
      $display("FAIL basic_wr0: got %h required %h", (wr_q.size() > 0 ? wr_q[0] : '0), {32'h100, 32'h04030201, 4'hF});
    end
    n_checks++;
    if ((wr_q.size() > 1 ? wr_q[1] : '0) !== {32'h104, 32'h08070605, 4'hF}) begin
      n_errors++;
      $display("FAIL basic_wr1: got %h required %h", (wr_q.size() > 1 ? wr_q[1] : '0), {32'h104, 32'h08070605, 4'hF});
    end
    n_checks++;
    if (checksum !== 32'h24) begin
      n_errors++;
      $display("FAIL basic_checksum: got %h required 00000024", checksum);
    end
    n_checks++;
    if ({done, error, busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL basic_status: done,error,busy=%b required 100", {done, error, busy});
    end
    n_checks++;
    if (cyc !== 14) begin
      n_errors++;
      $display("FAIL basic_latency: got %0d cycles required 14", cyc);
    end
    n_checks++;
    if (rd_errors(32'h100, 8) !== 0) begin
      n_errors++;
      $display("FAIL basic_reads: bad read entries=%0d required 0", rd_errors(32'h100, 8));
    end
  endtask

  task automatic test_tail();
    int cyc; logic b, d;
    tx_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(32'h2000, 16'd5, 5, 0, -1, cyc, b, d);
    n_checks++;
    if ((wr_q.size() > 1 ? wr_q[1] : '0) !== {32'h2004, 32'h000000EE, 4'b0001}) begin
      n_errors++;
      $display("FAIL tail_wr1: got %h required %h", (wr_q.size() > 1 ? wr_q[1] : '0), {32'h2004, 32'h000000EE, 4'b0001});
    end
    n_checks++;
    if ({done, error} !== 2'b10) begin
      n_errors++;
      $display("FAIL tail_status: done,error=%b required 10", {done, error});
    end
    n_checks++;
    if (checksum !== 32'h3FC || cyc !== 11) begin
      n_errors++;
      $display("FAIL tail_sum_latency: sum=%h cyc=%0d required 000003fc 11", checksum, cyc);
    end
  endtask

  task automatic test_gaps();
    int cyc; logic b, d;
    logic [31:0] base = {$urandom_range(32'hFFFF), 16'h0};
    tx_bytes.delete();
    for (int i = 0; i < 16; i++) tx_bytes.push_back(8'($urandom()));
    run_load(base, 16'd16, 16, 50, -1, cyc, b, d);
    n_checks++;
    if (wr_errors(base, 16) !== 0) begin
      n_errors++;
      $display("FAIL gaps_writes: bad entries=%0d required 0", wr_errors(base, 16));
    end
    n_checks++;
    if (img_errors(base, 16) !== 0) begin
      n_errors++;
      $display("FAIL gaps_image: bad bytes=%0d required 0", img_errors(base, 16));
    end
    n_checks++;
    if (checksum !== sum_bytes(16) || {done, error} !== 2'b10) begin
      n_errors++;
      $display("FAIL gaps_result: sum=%h done,error=%b required %h 10", checksum, {done, error}, sum_bytes(16));
    end
  endtask

  task automatic test_verify_error();
    int cyc; logic b, d;
    tx_bytes.delete();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'($urandom()));
    flip_en = 1'b1;
    flip_addr = 32'h304;
    run_load(32'h300, 16'd8, 8, 0, -1, cyc, b, d);
    flip_en = 1'b0;
    n_checks++;
    if ({done, error} !== 2'b11) begin
      n_errors++;
      $display("FAIL verify_error: done,error=%b required 11", {done, error});
    end
    n_checks++;
    if (wr_errors(32'h300, 8) !== 0) begin
      n_errors++;
      $display("FAIL verify_writes: bad entries=%0d required 0", wr_errors(32'h300, 8));
    end
  endtask

  task automatic test_zero_len();
    int cyc; logic b, d;
    tx_bytes.delete();
    run_load(32'h400, 16'd0, 0, 0, -1, cyc, b, d);
    n_checks++;
    if (d !== 1'b1 || cyc > 1) begin
      n_errors++;
      $display("FAIL zero_done: done=%b cyc=%0d required 1 within 1", d, cyc);
    end
    n_checks++;
    if (wr_q.size() !== 0 || rd_q.size() !== 0) begin
      n_errors++;
      $display("FAIL zero_bus: writes=%0d reads=%0d required 0 0", wr_q.size(), rd_q.size());
    end
    n_checks++;
    if ({checksum, error, busy} !== 34'd0) begin
      n_errors++;
      $display("FAIL zero_status: sum=%h error=%b busy=%b required 0", checksum, error, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, idx, guard; logic b, d;
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    @(negedge clk);
    start = 1'b1; len = 16'd8; base_addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 3 && guard < 20) begin
      s_valid = 1'b1;
      s_data = tx_bytes[idx];
      if (s_ready) idx++;
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (checksum !== 32'h66 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midload_progress: sum=%h busy=%b required 00000066 1", checksum, busy);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, mem_wmask, mem_rstrb, busy, done, error, mem_addr, mem_wdata, checksum} !== '0) begin
      n_errors++;
      $display("FAIL midload_reset: ctrl=%b addr=%h wdata=%h sum=%h required all 0",
               {s_ready, mem_wmask, mem_rstrb, busy, done, error}, mem_addr, mem_wdata, checksum);
    end
    @(negedge clk);
    resetn = 1'b1;
    tx_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_load(32'h600, 16'd4, 4, 0, -1, cyc, b, d);
    n_checks++;
    if (wr_errors(32'h600, 4) !== 0 || checksum !== 32'h30A || {done, error} !== 2'b10) begin
      n_errors++;
      $display("FAIL restart_load: bad writes=%0d sum=%h done,error=%b required 0 0000030a 10",
               wr_errors(32'h600, 4), checksum, {done, error});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, n; logic b, d;
    logic [31:0] base;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 13 : $urandom_range(13, 1);
      base = (it == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(3))) : $urandom();
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom()));
      run_load(base, 16'(n), n, 30, 2, cyc, b, d);
      n_checks++;
      if (wr_errors(base, n) !== 0 || rd_errors(base, n) !== 0) begin
        n_errors++;
        $display("FAIL b2b_bus[%0d]: bad writes=%0d bad reads=%0d required 0 0", it, wr_errors(base, n), rd_errors(base, n));
      end
      n_checks++;
      if (checksum !== sum_bytes(n) || {done, error} !== 2'b10) begin
        n_errors++;
        $display("FAIL b2b_result[%0d]: sum=%h done,error=%b required %h 10", it, checksum, {done, error}, sum_bytes(n));
      end
    end
  endtask

  task automatic test_clamp();
    int cyc; logic b, d;
    tx_bytes.delete();
    for (int i = 0; i < 8192; i++) tx_bytes.push_back(8'($urandom()));
    run_load(32'h1_0000, 16'hFFFF, 8192, 0, -1, cyc, b, d);
    n_checks++;
    if (wr_errors(32'h1_0000, 8192) !== 0 || cyc !== 14336) begin
      n_errors++;
      $display("FAIL clamp_writes: bad entries=%0d cyc=%0d required 0 14336", wr_errors(32'h1_0000, 8192), cyc);
    end
    n_checks++;
    if (checksum !== sum_bytes(8192) || {done, error} !== 2'b10) begin
      n_errors++;
      $display("FAIL clamp_result: sum=%h done,error=%b required %h 10", checksum, {done, error}, sum_bytes(8192));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail();
    test_gaps();
    test_verify_error();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    test_clamp();
    n_checks++;
    if (viol !== 0) begin
      n_errors++;
      $display("FAIL bus_exclusive: wmask+rstrb overlap cycles=%0d required 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
